// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helper functions for the UART receive path.
//   rx_state_t   : receiver FSM encoding (also exposed on the debug bus)
//   UART_DATA_BITS: payload bits per frame
//   calc_half()  : half bit period in clock cycles (integer division)
//   even_parity(): XOR reduction of a data byte
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   function automatic int calc_half(input int clks);
      return clks / 2;
   endfunction

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_if
// Output bundle of the UART receiver towards the UART top.
//   data_o       : last received byte, held until the next frame completes
//   valid_o      : 1-cycle pulse, data_o updated with a good frame
//   frame_err_o  : 1-cycle pulse, stop bit sampled low
//   busy_o       : high from start detection until return to IDLE
//   parity_err_o : 1-cycle pulse with the stop outcome on bad even parity
//                  (only when UART_RX_PARITY_EN is defined)
//   state        : receiver FSM state, for observation only
// Handshake: valid_o and frame_err_o are single-cycle strobes with no ready
// back-pressure; the consumer must capture data_o in the cycle valid_o is high
// (data_o stays stable afterwards until the next frame completes). The two
// strobes are mutually exclusive.
// Modports: master = receiver side, slave = consumer side.
// Macro: UART_RX_PARITY_EN adds parity_err_o.
// -----------------------------------------------------------------------------
interface uart_rx_frame_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data_o;
   logic                      valid_o;
   logic                      frame_err_o;
   logic                      busy_o;
`ifdef UART_RX_PARITY_EN
   logic                      parity_err_o;
`endif
   rx_state_t                 state;

   modport master (
      output data_o,
      output valid_o,
      output frame_err_o,
      output busy_o,
`ifdef UART_RX_PARITY_EN
      output parity_err_o,
`endif
      output state
   );

   modport slave (
      input data_o,
      input valid_o,
      input frame_err_o,
      input busy_o,
`ifdef UART_RX_PARITY_EN
      input parity_err_o,
`endif
      input state
   );

endinterface

// File: rtl/uart_sync_ff.sv
// -----------------------------------------------------------------------------
// uart_sync_ff
// Flop chain bringing the asynchronous serial line into the clk_i domain.
// Flops reset to 1 so an idle line never looks like a start bit after reset.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (last stage)
// -----------------------------------------------------------------------------
module uart_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= '1;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity bit,
// 1 stop bit. The line is oversampled with a bit-period counter; the start
// bit is re-checked at its half point and every later sample lands mid-bit.
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset
//   rx_i  : asynchronous serial line, idle high
//   bus   : uart_rx_frame_if.master (data_o, valid_o, frame_err_o, busy_o,
//           parity_err_o when enabled, state)
// Parameters:
//   CLKS_PER_BIT : clk_i cycles per bit (4..65535)
//   SYNC_STAGES  : synchroniser depth on rx_i (2..3)
// Macro: UART_RX_PARITY_EN adds the PARITY state and parity_err_o.
// -----------------------------------------------------------------------------
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_i,
   uart_rx_frame_if.master  bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = calc_half(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

   logic rx_s;

   rx_state_t                 state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                      par_q, par_d;
   logic                      perr_q, perr_d;
`endif

   uart_sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (rx_i),
      .q_o   (rx_s)
   );

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            // Half-bit check rejects glitches and aligns later samples mid-bit.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // Shift in at the MSB so bit 0 ends up at the LSB after 8 bits.
               shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               data_d = shreg_q;
`ifdef UART_RX_PARITY_EN
               perr_d = even_parity(shreg_q) ^ par_q;
`endif
               if (rx_s) begin
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BREAK: begin
            // A held-low line must not be mistaken for a new start bit.
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.data_o      = data_q;
   assign bus.valid_o     = valid_q;
   assign bus.frame_err_o = ferr_q;
   assign bus.busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err_o = perr_q;
`endif
   assign bus.state       = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Bench for uart_rx_frame with CLKS_PER_BIT=8, SYNC_STAGES=2.
// Expected output events are queued as {valid, frame_err, parity_err, data}
// when a frame is driven and compared when the receiver strobes.
// Macro: UART_RX_PARITY_EN enables the parity bit and parity_err_o checks.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;
   import uart_pkg::*;

   localparam int CPB  = 8;
   localparam int SYNC = 2;
   localparam int W    = 11;

   logic clk;
   logic rst_i;
   logic rx_i;

   uart_rx_frame_if rx_if ();

   uart_rx_frame #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .rx_i  (rx_i),
      .bus   (rx_if.master)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int exp_valid = 0;
   int last_valid_cyc = 0;
   int frame_start_cyc = 0;

   logic perr_obs;
`ifdef UART_RX_PARITY_EN
   assign perr_obs = rx_if.parity_err_o;
`else
   assign perr_obs = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      frame_start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(stop_bit);
   endtask

   // Expected parity error for a byte sent with parity bit par_bit.
   function automatic logic exp_perr(input logic [7:0] b, input logic par_bit);
`ifdef UART_RX_PARITY_EN
      return (^b) ^ par_bit;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push_good(input logic [7:0] b, input logic par_bit);
      exp_q.push_back({1'b1, 1'b0, exp_perr(b, par_bit), b});
      exp_valid++;
   endtask

   task automatic push_ferr(input logic [7:0] b, input logic par_bit);
      exp_q.push_back({1'b0, 1'b1, exp_perr(b, par_bit), b});
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] obs;
      logic [W-1:0] e;
      if (!rst_i && (rx_if.valid_o || rx_if.frame_err_o)) begin
         obs = {rx_if.valid_o, rx_if.frame_err_o, perr_obs, rx_if.data_o};
         check("strobe_excl", rx_if.valid_o & rx_if.frame_err_o, 0);
         if (rx_if.valid_o) begin
            n_valid++;
            last_valid_cyc = cyc;
            check("busy_at_valid", rx_if.busy_o, 0);
         end
         if (rx_if.frame_err_o) n_ferr++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", obs, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_out", obs, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int v0;
      int f0;
      logic [7:0] b2b[3];
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h81;

      rst_i = 1'b1;
      rx_i  = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data", rx_if.data_o, 8'h00);
      check("rst_valid", rx_if.valid_o, 0);
      check("rst_ferr", rx_if.frame_err_o, 0);
      check("rst_busy", rx_if.busy_o, 0);
      check("rst_state", rx_if.state, IDLE);
      rst_i = 1'b0;
      repeat (4) @(negedge clk);

      // Good frame and latency from start edge to valid_o.
      push_good(8'h55, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0);
      wait_drain(20 * CPB);
      check("good_data", rx_if.data_o, 8'h55);
      check("latency", last_valid_cyc - frame_start_cyc, (19 * CPB) / 2 + SYNC + 1);
      repeat (2) @(negedge clk);
      check("good_busy_after", rx_if.busy_o, 0);

      // Start-bit glitch.
      v0 = n_valid;
      f0 = n_ferr;
      rx_i = 1'b0;
      repeat (3) @(negedge clk);
      rx_i = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_valid", n_valid - v0, 0);
      check("glitch_ferr", n_ferr - f0, 0);
      check("glitch_busy", rx_if.busy_o, 0);
      push_good(8'hA3, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0);
      wait_drain(20 * CPB);

      // Framing error followed by a held-low break.
      v0 = n_valid;
      f0 = n_ferr;
      push_ferr(8'hF0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      wait_drain(4);
      check("break_ferr_cnt", n_ferr - f0, 1);
      check("break_valid_cnt", n_valid - v0, 0);
      check("break_data", rx_if.data_o, 8'hF0);
      check("break_busy", rx_if.busy_o, 1);
      rx_i = 1'b1;
      repeat (6) @(negedge clk);
      check("break_exit_busy", rx_if.busy_o, 0);
      push_good(8'h0F, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);
      wait_drain(20 * CPB);
      check("after_break_data", rx_if.data_o, 8'h0F);

      // Back-to-back frames, no idle gap.
      for (int i = 0; i < 3; i++) begin
         push_good(b2b[i], ^b2b[i]);
         send_frame(b2b[i], 1'b1, ^b2b[i]);
      end
      wait_drain(20 * CPB);

      // Reset during bit 4 of 0x3C.
      rx_i = 1'b1;
      repeat (4) @(negedge clk);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ ((8'h3C >> i) & 1));
      rx_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      #1;
      check("midrst_data", rx_if.data_o, 8'h00);
      check("midrst_valid", rx_if.valid_o, 0);
      check("midrst_ferr", rx_if.frame_err_o, 0);
      check("midrst_busy", rx_if.busy_o, 0);
      check("midrst_state", rx_if.state, IDLE);
      repeat (4) @(negedge clk);
      rst_i = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      push_good(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      wait_drain(20 * CPB);
      check("after_rst_data", rx_if.data_o, 8'h3C);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so parity 1 is good, 0 is bad.
      push_good(8'h07, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      wait_drain(20 * CPB);
      push_good(8'h07, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_drain(20 * CPB);
`endif

      // Random good frames.
      for (int i = 0; i < 4; i++) begin
         logic [7:0] rb;
         logic       rp;
         rb = 8'($urandom_range(0, 255));
         rp = 1'($urandom_range(0, 1));
         push_good(rb, rp);
         send_frame(rb, 1'b1, rp);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      wait_drain(20 * CPB);

      repeat (2 * CPB) @(negedge clk);
      check("total_valid", n_valid, exp_valid);
      check("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver; the receive-side counterpart of the 10-bit serial transmit register.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); optional even-parity bit between data and stop.
- Samples the asynchronous serial line in the system clock domain using an internal bit-period counter.
- Delivers each received byte as a 1-cycle valid pulse to the UART top.

Parameters:
- CLKS_PER_BIT, 434, clk_i cycles per bit period (50 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, synchronizer flops on rx_i; legal range 2..3.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial line; asynchronous; idle high.
- data_o  output  8  last received byte; held until the next frame completes.
- valid_o  output  1  1-cycle pulse: data_o updated with a good frame.
- frame_err_o  output  1  1-cycle pulse: stop bit sampled 0.
- busy_o  output  1  high from start detection until return to IDLE.

Behaviour:
- Reset: state=IDLE, data_o=8'h00, valid_o=0, frame_err_o=0, busy_o=0, counters=0, synchronizer flops=1.
- rx_i passes through SYNC_STAGES flops and the result is rx_s; all decisions use rx_s.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. Half point is HALF=CLKS_PER_BIT/2, using integer division.
- IDLE:
  - On rx_s=0, go to START with cnt=0 and busy_o=1.
- START:
  - At cnt=HALF-1, re-sample rx_s.
  - If rx_s=1, treat it as a glitch: go to IDLE, busy_o=0, no pulse.
  - Otherwise go to DATA with cnt=0 and bit index idx=0. From here every sample lands mid-bit.
- DATA:
  - At cnt=CLKS_PER_BIT-1, shift rx_s into the shift register MSB and shift right, so bit 0 arrives first.
  - idx increments; after idx=7 is sampled, go to STOP (or PARITY if enabled).
- STOP:
  - At cnt=CLKS_PER_BIT-1, sample rx_s and load data_o from the shift register in both cases.
  - rx_s=1: valid_o=1 for 1 cycle, go to IDLE, busy_o drops the same cycle.
  - rx_s=0: frame_err_o=1 for 1 cycle, valid_o stays 0, go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE.
  - A held-low line (break) raises exactly one frame_err_o and never re-triggers a start.
- Latency: valid_o rises 9.5 bit periods + SYNC_STAGES + 1 clk_i cycles after the start falling edge on rx_i.
- Back-to-back frames: the next start edge is detected the first cycle after IDLE is re-entered. The half-stop-bit margin gives 0.5 bit of tolerance.
- valid_o and frame_err_o are never high in the same cycle.
- Reset mid-frame: immediately returns to IDLE and clears all outputs; the partial byte is discarded.
- Width rules:
  - cnt width is $clog2(CLKS_PER_BIT); it never wraps past CLKS_PER_BIT-1.
  - idx is 3 bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY after DATA, which samples 1 bit at the mid point.
  - Adds output parity_err_o (1 bit, reset 0).
  - parity_err_o pulses 1 cycle together with the STOP outcome when (XOR of data bits) XOR parity bit = 1 (even parity).
  - valid_o is still asserted on a good stop; the consumer qualifies it with parity_err_o.
- Undefined:
  - No PARITY state and no parity_err_o port; the frame is exactly 10 bits.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - localparam UART_DATA_BITS=8.
  - Functions calc_half(clks) and even_parity(byte).
- Sub-module uart_sync_ff: SYNC_STAGES-deep flop chain, reset value 1, async rst_i.

Test Plan (CLKS_PER_BIT=8, SYNC_STAGES=2):
- Good frame: send 0x55 (start, 10101010 LSB first, stop) -> one valid_o pulse, data_o=8'h55, frame_err_o=0, busy_o low the cycle after valid_o.
- Glitch: rx_i low for 3 clk_i cycles then high -> returns to IDLE, no valid_o, no frame_err_o; a following frame 0xA3 is received correctly.
- Framing error: send 0xF0 with stop bit 0, then hold rx_i low 40 cycles -> exactly one frame_err_o, valid_o never high, data_o=8'hF0; rx_i high then frame 0x0F -> valid_o with data_o=8'h0F.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three valid_o pulses, data_o 8'h00, 8'hFF, 8'h81 in order.
- Reset mid-frame: assert rst_i during bit 4 of 0x3C -> all outputs 0 immediately; after release, a fresh 0x3C is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity 1 -> valid_o, parity_err_o=0; 0x07 with parity 0 -> valid_o and parity_err_o=1 in the same cycle.
